// File: rtl/bullet_pool_ctrl.sv
// Shared bullet-slot pool for two players: request latching, cooldown, per-player limits, round-robin grant.
// Optional per-player launch/drop counters are enabled by defining BULLET_POOL_STATS_EN.
module bullet_pool_ctrl #(
  parameter int NUM_SLOTS       = 4,
  parameter int COOLDOWN_FRAMES = 3,
  parameter int MAX_PER_PLAYER  = 2,
  parameter int ACK_TIMEOUT     = 4
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_frame_tick,
  input  logic [1:0]           i_fire_req,
  input  logic [1:0]           i_defend,
  input  logic [10:0]          i_x_p0,
  input  logic [9:0]           i_y_p0,
  input  logic [10:0]          i_x_p1,
  input  logic [9:0]           i_y_p1,
  input  logic [NUM_SLOTS-1:0] i_slot_busy,
  output logic [NUM_SLOTS-1:0] o_launch,
  output logic [10:0]          o_launch_x,
  output logic [9:0]           o_launch_y,
  output logic                 o_launch_owner,
  output logic [NUM_SLOTS-1:0] o_owner_map,
  output logic [1:0]           o_fire_ack,
  output logic                 o_timeout_err
`ifdef BULLET_POOL_STATS_EN
  ,
  output logic [15:0]          o_launch_cnt0,
  output logic [15:0]          o_launch_cnt1,
  output logic [15:0]          o_drop_cnt0,
  output logic [15:0]          o_drop_cnt1
`endif
);

  localparam int SW = $clog2(NUM_SLOTS);
  localparam int HW = $clog2(NUM_SLOTS + 1);
  localparam int CW = (COOLDOWN_FRAMES > 0) ? $clog2(COOLDOWN_FRAMES + 1) : 1;
  localparam int TW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;

  typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT} state_t;

  state_t               r_state, w_state_nxt;
  logic [NUM_SLOTS-1:0] r_reserved, r_owner, r_launch;
  logic [SW-1:0]        r_slot, w_slot;
  logic [TW-1:0]        r_cnt;
  logic [CW-1:0]        r_cool [2];
  logic [1:0]           r_pending, r_fire_ack, w_elig, w_grant;
  logic                 r_rr, r_launch_owner, r_timeout_err;
  logic [10:0]          r_launch_x;
  logic [9:0]           r_launch_y;
  logic [NUM_SLOTS-1:0] w_free, w_occ;
  logic [HW-1:0]        w_held0, w_held1;
  logic                 w_any_free, w_win, w_contend, w_done_ok, w_done_to;

  assign w_occ      = r_reserved | i_slot_busy;
  assign w_free     = ~w_occ;
  assign w_any_free = |w_free;

  // Lowest free slot and per-player occupancy in one sweep
  always_comb begin
    w_slot  = '0;
    w_held0 = '0;
    w_held1 = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (w_free[i]) w_slot = SW'(i);
      w_held0 = w_held0 + HW'(w_occ[i] & ~r_owner[i]);
      w_held1 = w_held1 + HW'(w_occ[i] & r_owner[i]);
    end
  end

  // A player holding defend is never granted, even in the cycle its request is dropped
  assign w_elig[0] = r_pending[0] & ~i_defend[0] & (r_cool[0] == '0) &
                     (w_held0 < HW'(MAX_PER_PLAYER)) & w_any_free;
  assign w_elig[1] = r_pending[1] & ~i_defend[1] & (r_cool[1] == '0) &
                     (w_held1 < HW'(MAX_PER_PLAYER)) & w_any_free;
  assign w_contend = &w_elig;
  assign w_win     = w_contend ? r_rr : w_elig[1];

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (|w_elig) w_state_nxt = S_LAUNCH;
      S_LAUNCH: w_state_nxt = S_WAIT;
      S_WAIT:   if (i_slot_busy[r_slot] || r_cnt == TW'(ACK_TIMEOUT - 1)) w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_grant   = 2'b00;
    w_done_ok = 1'b0;
    w_done_to = 1'b0;
    case (r_state)
      S_IDLE:  if (|w_elig) w_grant = w_win ? 2'b10 : 2'b01;
      S_WAIT: begin
        w_done_ok = i_slot_busy[r_slot];
        w_done_to = ~i_slot_busy[r_slot] & (r_cnt == TW'(ACK_TIMEOUT - 1));
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_reserved     <= '0;
      r_owner        <= '0;
      r_slot         <= '0;
      r_cnt          <= '0;
      r_pending      <= '0;
      r_cool[0]      <= '0;
      r_cool[1]      <= '0;
      r_rr           <= 1'b0;
      r_launch       <= '0;
      r_launch_x     <= '0;
      r_launch_y     <= '0;
      r_launch_owner <= 1'b0;
      r_fire_ack     <= '0;
      r_timeout_err  <= 1'b0;
    end else begin
      r_launch       <= '0;
      r_launch_x     <= '0;
      r_launch_y     <= '0;
      r_launch_owner <= 1'b0;
      r_fire_ack     <= w_grant;
      for (int p = 0; p < 2; p++) begin
        r_pending[p] <= ((r_pending[p] & ~w_grant[p]) | i_fire_req[p]) & ~i_defend[p];
        if (w_grant[p])
          r_cool[p] <= CW'(COOLDOWN_FRAMES);
        else if (i_frame_tick && r_cool[p] != '0)
          r_cool[p] <= r_cool[p] - CW'(1);
      end
      if (|w_grant) begin
        r_reserved[w_slot] <= 1'b1;
        r_owner[w_slot]    <= w_win;
        r_slot             <= w_slot;
        r_launch           <= NUM_SLOTS'(1) << w_slot;
        r_launch_x         <= w_win ? i_x_p1 : i_x_p0;
        r_launch_y         <= w_win ? i_y_p1 : i_y_p0;
        r_launch_owner     <= w_win;
        if (w_contend) r_rr <= ~w_win;
      end
      if (r_state == S_LAUNCH)  r_cnt <= '0;
      else if (r_state == S_WAIT) r_cnt <= r_cnt + TW'(1);
      if (w_done_ok || w_done_to) r_reserved[r_slot] <= 1'b0;
      if (w_done_to) r_timeout_err <= 1'b1;
    end
  end

  assign o_launch       = r_launch;
  assign o_launch_x     = r_launch_x;
  assign o_launch_y     = r_launch_y;
  assign o_launch_owner = r_launch_owner;
  assign o_owner_map    = r_owner;
  assign o_fire_ack     = r_fire_ack;
  assign o_timeout_err  = r_timeout_err;

`ifdef BULLET_POOL_STATS_EN
  logic [15:0] r_lcnt [2];
  logic [15:0] r_dcnt [2];

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_lcnt[0] <= '0;
      r_lcnt[1] <= '0;
      r_dcnt[0] <= '0;
      r_dcnt[1] <= '0;
    end else begin
      for (int p = 0; p < 2; p++) begin
        if (r_fire_ack[p]) r_lcnt[p] <= r_lcnt[p] + 16'd1;
        if (r_pending[p] & ~w_grant[p] & (i_defend[p] | i_fire_req[p]))
          r_dcnt[p] <= r_dcnt[p] + 16'd1;
      end
    end
  end

  assign o_launch_cnt0 = r_lcnt[0];
  assign o_launch_cnt1 = r_lcnt[1];
  assign o_drop_cnt0   = r_dcnt[0];
  assign o_drop_cnt1   = r_dcnt[1];
`endif

endmodule

// File: tb/tb_bullet_pool_ctrl.sv
// Scoreboard bench for bullet_pool_ctrl: directed stimulus queues expected launches, a monitor checks them.
module tb_bullet_pool_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        frame_tick = 1'b0;
  logic [1:0]  fire_req = 2'b00;
  logic [1:0]  defend = 2'b00;
  logic [10:0] x0 = 11'd100, x1 = 11'd300;
  logic [9:0]  y0 = 10'd200, y1 = 10'd400;
  logic [3:0]  busy = 4'b0000;
  logic [3:0]  launch, owner_map;
  logic [10:0] launch_x;
  logic [9:0]  launch_y;
  logic        launch_owner, timeout_err;
  logic [1:0]  fire_ack;
`ifdef BULLET_POOL_STATS_EN
  logic [15:0] lcnt0, lcnt1, dcnt0, dcnt1;
`endif

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  bit auto_busy = 1'b0;

  typedef struct {
    logic [3:0]  launch;
    logic [10:0] x;
    logic [9:0]  y;
    logic        owner;
    logic [1:0]  ack;
    int          cyc;
  } exp_t;
  exp_t q[$];

  bullet_pool_ctrl dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_frame_tick(frame_tick),
    .i_fire_req(fire_req), .i_defend(defend),
    .i_x_p0(x0), .i_y_p0(y0), .i_x_p1(x1), .i_y_p1(y1),
    .i_slot_busy(busy),
    .o_launch(launch), .o_launch_x(launch_x), .o_launch_y(launch_y),
    .o_launch_owner(launch_owner), .o_owner_map(owner_map),
    .o_fire_ack(fire_ack), .o_timeout_err(timeout_err)
`ifdef BULLET_POOL_STATS_EN
    , .o_launch_cnt0(lcnt0), .o_launch_cnt1(lcnt1),
    .o_drop_cnt0(dcnt0), .o_drop_cnt1(dcnt1)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Bullet units answer a launch with busy on the following edge when auto_busy is set
  task automatic tick();
    @(posedge clk);
    #1;
    if (auto_busy) busy = busy | launch;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) begin
      frame_tick = 1'b1;
      tick();
      frame_tick = 1'b0;
      tick();
    end
  endtask

  task automatic fire(input logic [1:0] f);
    fire_req = f;
    tick();
    fire_req = 2'b00;
  endtask

  task automatic expect_launch(input logic [3:0] l, input logic owner, input int at);
    exp_t e;
    e.launch = l;
    e.owner  = owner;
    e.x      = owner ? x1 : x0;
    e.y      = owner ? y1 : y0;
    e.ack    = owner ? 2'b10 : 2'b01;
    e.cyc    = at;
    q.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (launch != 4'b0 || fire_ack != 2'b0) begin
        if (q.size() == 0) begin
          chk("unexpected_launch", {28'd0, launch}, 32'd0);
        end else begin
          e = q.pop_front();
          chk("launch", {28'd0, launch}, {28'd0, e.launch});
          chk("launch_x", {21'd0, launch_x}, {21'd0, e.x});
          chk("launch_y", {22'd0, launch_y}, {22'd0, e.y});
          chk("launch_owner", {31'd0, launch_owner}, {31'd0, e.owner});
          chk("fire_ack", {30'd0, fire_ack}, {30'd0, e.ack});
          if (e.cyc >= 0) chk("launch_cycle", cyc, e.cyc);
        end
      end
    end
  end

  initial begin : stim
    int n0;
    ticks(3);
    chk("rst_launch", {28'd0, launch}, 32'd0);
    chk("rst_ack", {30'd0, fire_ack}, 32'd0);
    chk("rst_owner_map", {28'd0, owner_map}, 32'd0);
    chk("rst_timeout", {31'd0, timeout_err}, 32'd0);
    chk("rst_launch_x", {21'd0, launch_x}, 32'd0);
    rst_n = 1'b1;
    tick();

    // Single P0 shot, launch two cycles after the request
    auto_busy = 1'b1;
    expect_launch(4'b0001, 1'b0, cyc + 2);
    fire(2'b01);
    ticks(6);
    chk("t1_owner_map", {28'd0, owner_map}, 32'd0);
    chk("t1_timeout", {31'd0, timeout_err}, 32'd0);
    busy = 4'b0000;
    frames(3);

    // Contention: P0 first, then P1; next contention favours P1
    expect_launch(4'b0001, 1'b0, -1);
    expect_launch(4'b0010, 1'b1, -1);
    fire(2'b11);
    ticks(10);
    chk("t2_owner_map_a", {28'd0, owner_map}, 32'd2);
    frames(3);
    expect_launch(4'b0100, 1'b1, -1);
    expect_launch(4'b1000, 1'b0, -1);
    fire(2'b11);
    ticks(10);
    chk("t2_owner_map_b", {28'd0, owner_map}, 32'd6);
    busy = 4'b0000;
    ticks(2);
    frames(3);

    // Cooldown: second request waits for the third frame_tick
    expect_launch(4'b0001, 1'b0, -1);
    fire(2'b01);
    ticks(4);
    frames(2);
    fire(2'b01);
    ticks(5);
    expect_launch(4'b0010, 1'b0, cyc + 2);
    frames(1);
    ticks(4);
    chk("t3_busy", {28'd0, busy}, 32'd3);

    // Per-player limit: two busy slots block P0 until one frees
    frames(3);
    fire(2'b01);
    ticks(6);
    chk("t4_owner_map", {28'd0, owner_map}, 32'd4);
    expect_launch(4'b0001, 1'b0, cyc + 1);
    busy = 4'b0010;
    ticks(5);
    busy = 4'b0000;
    ticks(2);

    // Ack timeout: slot never reports busy
    auto_busy = 1'b0;
    frames(3);
    x0 = 11'd5; y0 = 10'd6;
    n0 = cyc;
    expect_launch(4'b0001, 1'b0, n0 + 2);
    fire(2'b01);
    while (cyc < n0 + 6) tick();
    chk("t5_timeout_early", {31'd0, timeout_err}, 32'd0);
    tick();
    chk("t5_timeout_set", {31'd0, timeout_err}, 32'd1);
    frames(3);
    auto_busy = 1'b1;
    x0 = 11'd7; y0 = 10'd8;
    expect_launch(4'b0001, 1'b0, cyc + 2);
    fire(2'b01);
    ticks(5);
    chk("t5_timeout_sticky", {31'd0, timeout_err}, 32'd1);
    busy = 4'b0000;
    frames(3);

    // Defend right after a request drops it
    fire(2'b01);
    defend = 2'b01;
    tick();
    defend = 2'b00;
    ticks(6);
`ifdef BULLET_POOL_STATS_EN
    chk("drop_cnt0", {16'd0, dcnt0}, 32'd1);
    chk("launch_cnt0", {16'd0, lcnt0}, 32'd8);
    chk("launch_cnt1", {16'd0, lcnt1}, 32'd2);
`endif

    // Reset in WAIT_BUSY clears outputs, reservations and cooldowns
    auto_busy = 1'b0;
    x0 = 11'd9; y0 = 10'd10;
    n0 = cyc;
    expect_launch(4'b0001, 1'b0, n0 + 2);
    fire(2'b01);
    while (cyc < n0 + 3) tick();
    rst_n = 1'b0;
    tick();
    chk("t7_launch", {28'd0, launch}, 32'd0);
    chk("t7_owner_map", {28'd0, owner_map}, 32'd0);
    chk("t7_timeout", {31'd0, timeout_err}, 32'd0);
    chk("t7_ack", {30'd0, fire_ack}, 32'd0);
    rst_n = 1'b1;
    auto_busy = 1'b1;
    x0 = 11'd11; y0 = 10'd12;
    expect_launch(4'b0001, 1'b0, cyc + 2);
    fire(2'b01);
    ticks(6);

    chk("pending_expectations", q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
